// File: rtl/fetch_sequencer.sv
// Program-counter / mode sequencer for the 9-bit instruction decoder: IDLE -> FETCH -> EXEC -> DONE.
// Optional run-cycle counter enabled by defining SEQ_CYCLE_COUNT_EN.
module fetch_sequencer #(
  parameter int PC_WIDTH    = 10,
  parameter int INSTR_WIDTH = 9,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [INSTR_WIDTH-1:0] mach_code,
  output logic                   modeQ,
  output logic                   instr_valid,
  input  logic                   mode_next,
  input  logic                   branch_en,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic                   halt,
  input  logic                   mem_busy,
  output logic                   done,
  output logic [PC_WIDTH-1:0]    pc
`ifdef SEQ_CYCLE_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0]   cycle_count
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;

  state_t state;

  if (PC_WIDTH < 1 || INSTR_WIDTH < 1 || CNT_WIDTH < 1) begin : g_param_check
    $error("fetch_sequencer: widths must be positive");
  end

  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      mach_code   <= '0;
      modeQ       <= 1'b0;
      instr_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pc    <= '0;
            modeQ <= 1'b0;
            state <= FETCH;
          end
        end
        FETCH: begin
          // The word addressed during FETCH is captured at the FETCH->EXEC edge
          mach_code   <= imem_data;
          instr_valid <= 1'b1;
          state       <= EXEC;
        end
        EXEC: begin
          if (mem_busy) begin
            state <= EXEC;
          end else if (halt) begin
            instr_valid <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            pc          <= branch_en ? branch_target : pc + 1'b1;
            modeQ       <= mode_next;
            instr_valid <= 1'b0;
            state       <= FETCH;
          end
        end
        DONE: begin
          if (start) begin
            pc    <= '0;
            modeQ <= 1'b0;
            done  <= 1'b0;
            state <= FETCH;
          end
        end
      endcase
    end
  end

`ifdef SEQ_CYCLE_COUNT_EN
  // Counts FETCH and EXEC cycles of the current run; frozen in DONE, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= '0;
    end else if ((state == IDLE || state == DONE) && start) begin
      cycle_count <= '0;
    end else if ((state == FETCH || state == EXEC) && cycle_count != {CNT_WIDTH{1'b1}}) begin
      cycle_count <= cycle_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Table-driven bench for fetch_sequencer: one vector per clock, plus a hand-written async reset sequence.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [9:0] imem_addr;
  logic [8:0] imem_data;
  logic [8:0] mach_code;
  logic       modeQ, instr_valid, mode_next, branch_en, halt, mem_busy, done;
  logic [9:0] branch_target;
  logic [9:0] pc;
`ifdef SEQ_CYCLE_COUNT_EN
  logic [15:0] cycle_count;
`endif

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_addr(imem_addr), .imem_data(imem_data), .mach_code(mach_code),
    .modeQ(modeQ), .instr_valid(instr_valid), .mode_next(mode_next),
    .branch_en(branch_en), .branch_target(branch_target), .halt(halt),
    .mem_busy(mem_busy), .done(done), .pc(pc)
`ifdef SEQ_CYCLE_COUNT_EN
    , .cycle_count(cycle_count)
`endif
  );

  function automatic logic [8:0] rom_word(input logic [9:0] a);
    logic [19:0] t;
    t = a * 20'd13 + 20'd37;
    return t[8:0];
  endfunction

  // Instruction ROM: returns the word addressed during FETCH by the capturing edge
  always_comb imem_data = rom_word(imem_addr);

  typedef struct {
    logic       st, mn, br, ht, mb;
    logic [9:0] tg;
    logic [9:0] e_pc;
    logic       e_mode, e_valid, e_done;
    logic [8:0] e_mc;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input logic st, input logic mn, input logic br, input logic [9:0] tg,
                     input logic ht, input logic mb, input logic [9:0] e_pc, input logic e_mode,
                     input logic e_valid, input logic e_done, input logic [8:0] e_mc);
    vec_t v;
    v.st = st; v.mn = mn; v.br = br; v.tg = tg; v.ht = ht; v.mb = mb;
    v.e_pc = e_pc; v.e_mode = e_mode; v.e_valid = e_valid; v.e_done = e_done; v.e_mc = e_mc;
    vecs.push_back(v);
  endtask

  task automatic check_outs(input string name, input logic [9:0] e_pc, input logic e_mode,
                            input logic e_valid, input logic e_done, input logic [8:0] e_mc);
    logic [31:0] got, exp;
    got = {imem_addr, pc, modeQ, instr_valid, done, mach_code};
    exp = {e_pc, e_pc, e_mode, e_valid, e_done, e_mc};
    checks++;
    if (got === exp) begin
      passes++;
      $display("ok   %s pc=%h addr=%h modeQ=%b valid=%b done=%b mc=%h", name, pc, imem_addr,
               modeQ, instr_valid, done, mach_code);
    end else begin
      $display("FAIL %s got pc=%h addr=%h modeQ=%b valid=%b done=%b mc=%h exp pc=%h modeQ=%b valid=%b done=%b mc=%h",
               name, pc, imem_addr, modeQ, instr_valid, done, mach_code,
               e_pc, e_mode, e_valid, e_done, e_mc);
    end
  endtask

`ifdef SEQ_CYCLE_COUNT_EN
  task automatic check_cnt(input string name, input logic [15:0] exp);
    checks++;
    if (cycle_count === exp) begin
      passes++;
      $display("ok   %s cycle_count=%0d", name, cycle_count);
    end else begin
      $display("FAIL %s cycle_count got %0d exp %0d", name, cycle_count, exp);
    end
  endtask
`endif

  initial begin
    // Straight-line run, start held high throughout (ignored in FETCH/EXEC), halt at addr 4
    row(1,0,0,10'h000,0,0, 10'h000,0,0,0, 9'h000);
    row(1,0,0,10'h000,0,0, 10'h000,0,1,0, rom_word(10'h000));
    row(1,0,0,10'h000,0,0, 10'h001,0,0,0, rom_word(10'h000));
    row(1,0,0,10'h000,0,0, 10'h001,0,1,0, rom_word(10'h001));
    row(1,0,0,10'h000,0,0, 10'h002,0,0,0, rom_word(10'h001));
    row(1,0,0,10'h000,0,0, 10'h002,0,1,0, rom_word(10'h002));
    row(1,0,0,10'h000,0,0, 10'h003,0,0,0, rom_word(10'h002));
    row(1,0,0,10'h000,0,0, 10'h003,0,1,0, rom_word(10'h003));
    row(1,0,0,10'h000,0,0, 10'h004,0,0,0, rom_word(10'h003));
    row(1,0,0,10'h000,0,0, 10'h004,0,1,0, rom_word(10'h004));
    row(1,0,0,10'h000,1,0, 10'h004,0,0,1, rom_word(10'h004));
    row(0,0,0,10'h000,0,0, 10'h004,0,0,1, rom_word(10'h004));
    // Restart from DONE, then mode toggles at addr 0 and 1
    row(1,0,0,10'h000,0,0, 10'h000,0,0,0, rom_word(10'h004));
    row(0,0,0,10'h000,0,0, 10'h000,0,1,0, rom_word(10'h000));
    row(0,1,0,10'h000,0,0, 10'h001,1,0,0, rom_word(10'h000));
    row(0,0,0,10'h000,0,0, 10'h001,1,1,0, rom_word(10'h001));
    row(0,1,0,10'h000,0,0, 10'h002,1,0,0, rom_word(10'h001));
    row(0,0,0,10'h000,0,0, 10'h002,1,1,0, rom_word(10'h002));
    // Branch at addr 2 stalled for 3 cycles; mode_next ignored while stalled
    row(0,0,1,10'h3F0,0,1, 10'h002,1,1,0, rom_word(10'h002));
    row(0,1,1,10'h3F0,0,1, 10'h002,1,1,0, rom_word(10'h002));
    row(0,0,1,10'h3F0,0,1, 10'h002,1,1,0, rom_word(10'h002));
    row(0,0,1,10'h3F0,0,0, 10'h3F0,0,0,0, rom_word(10'h002));
    row(0,0,0,10'h000,0,0, 10'h3F0,0,1,0, rom_word(10'h3F0));
    // Branch to all-ones, then sequential increment wraps to 0
    row(0,1,1,10'h3FF,0,0, 10'h3FF,1,0,0, rom_word(10'h3F0));
    row(0,0,0,10'h000,0,0, 10'h3FF,1,1,0, rom_word(10'h3FF));
    row(0,1,0,10'h000,0,0, 10'h000,1,0,0, rom_word(10'h3FF));
    row(0,0,0,10'h000,0,0, 10'h000,1,1,0, rom_word(10'h000));
    row(0,0,0,10'h000,0,0, 10'h001,0,0,0, rom_word(10'h000));
    row(0,0,0,10'h000,0,0, 10'h001,0,1,0, rom_word(10'h001));
    row(0,0,0,10'h000,0,0, 10'h002,0,0,0, rom_word(10'h001));
    row(0,0,0,10'h000,0,0, 10'h002,0,1,0, rom_word(10'h002));
    // Halt+branch under stall, then halt wins once the stall clears
    row(0,1,1,10'h155,1,1, 10'h002,0,1,0, rom_word(10'h002));
    row(0,1,1,10'h155,1,0, 10'h002,0,0,1, rom_word(10'h002));
    // New run reaching EXEC at pc=5 with modeQ=1
    row(1,0,0,10'h000,0,0, 10'h000,0,0,0, rom_word(10'h002));
    row(0,0,0,10'h000,0,0, 10'h000,0,1,0, rom_word(10'h000));
    row(0,1,1,10'h005,0,0, 10'h005,1,0,0, rom_word(10'h000));
    row(0,0,0,10'h000,0,0, 10'h005,1,1,0, rom_word(10'h005));

    rst_n = 1'b0; start = 1'b0; mode_next = 1'b0; branch_en = 1'b0;
    branch_target = '0; halt = 1'b0; mem_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 10'h000, 0, 0, 0, 9'h000);
`ifdef SEQ_CYCLE_COUNT_EN
    check_cnt("reset_cnt", 16'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].st; mode_next = vecs[i].mn; branch_en = vecs[i].br;
      branch_target = vecs[i].tg; halt = vecs[i].ht; mem_busy = vecs[i].mb;
      @(posedge clk);
      #1;
      check_outs($sformatf("vec%0d", i + 1), vecs[i].e_pc, vecs[i].e_mode,
                 vecs[i].e_valid, vecs[i].e_done, vecs[i].e_mc);
`ifdef SEQ_CYCLE_COUNT_EN
      if (i == 10 || i == 11) check_cnt($sformatf("cnt_vec%0d", i + 1), 16'd10);
      if (i == 12) check_cnt("cnt_restart", 16'd0);
      if (i == 13) check_cnt("cnt_first_exec", 16'd1);
`endif
    end

    // Asynchronous reset mid-EXEC: outputs clear without waiting for an edge
    start = 1'b1; mode_next = 1'b0; branch_en = 1'b0; halt = 1'b0; mem_busy = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_reset", 10'h000, 0, 0, 0, 9'h000);
`ifdef SEQ_CYCLE_COUNT_EN
    check_cnt("async_reset_cnt", 16'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outs("post_reset_fetch", 10'h000, 0, 0, 0, 9'h000);
    start = 1'b0;
    @(posedge clk);
    #1;
    check_outs("post_reset_exec", 10'h000, 0, 1, 0, rom_word(10'h000));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
